// File: rtl/demux1to4_8bit_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demultiplexer.
package demux1to4_8bit_buf_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        MODE_DIR = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

endpackage

// File: rtl/demux1to4_8bit_buf_chan_reg.sv
// One-entry output holding register with valid/ready handshake.
module demux_chan_reg
    import demux1to4_8bit_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             full;
    logic [WIDTH-1:0] data;

    // A full register may be refilled in the same cycle it drains.
    assign wr_ready  = ~full | out_ready;
    assign out_valid = full;
    assign out_data  = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (wr_en) begin
            full <= 1'b1;
            data <= wr_data;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1to4_8bit_buf.sv
// 1-to-4 demultiplexer with per-channel holding registers; directed or round-robin routing.
module demux1to4_8bit_buf
    import demux1to4_8bit_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = demux1to4_8bit_buf_pkg::NCH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [SEL_W-1:0]     rr_ptr,
    output logic [CNT_W-1:0]     xfer_cnt
);

    logic [SEL_W-1:0] dst;
    logic [NCH-1:0]   chan_rdy;
    logic             accept;

    always_comb begin
        dst      = (mode == MODE_RR) ? rr_ptr : sel;
        in_ready = rst_n & chan_rdy[dst];
        accept   = in_valid & in_ready;
    end

    // rr_ptr only moves on round-robin acceptances, so a stalled channel is never skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
            if (mode == MODE_RR) begin
                rr_ptr <= rr_ptr + SEL_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (accept && (dst == SEL_W'(k))),
            .wr_data  (in_data),
            .wr_ready (chan_rdy[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*WIDTH +: WIDTH]),
            .out_ready(out_ready[k])
        );
    end

endmodule
